// File: rtl/int_service_seq.sv
// Interrupt service sequencer for the LVDA: reads the status word over PIO, reports the
// highest-priority vector, then writes a one-hot reset mask back to retire that source.
module int_service_seq #(
    parameter logic [8:0]  RD_ADDR    = 9'h0A4,
    parameter logic [8:0]  CLR_ADDR   = 9'h0A5,
    parameter int unsigned NSRC       = 14,
    parameter int unsigned TMO_CYC    = 64,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            SINT,
    input  logic            INH,
    input  logic            SLOT,
    input  logic [NSRC-1:0] INT_STAT,
    input  logic            STAT_VLD,
    output logic            PIO_RD,
    output logic            PIO_WR,
    output logic [8:0]      PIO_ADDR,
    output logic [NSRC-1:0] PIO_DATA,
    output logic [3:0]      VEC,
    output logic            VEC_VLD,
    output logic            BUSY,
    output logic [7:0]      SPUR_CNT,
    output logic            TMO_ERR
);

    localparam int unsigned TMAX = (TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMO_LOAD    = TW'(TMO_CYC);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSlot,
        StWaitStat,
        StDispatch,
        StWaitSlot2,
        StSettle
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_sints;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [NSRC-1:0] r_stat, w_stat_nxt;
    logic [NSRC-1:0] r_mask, w_mask_nxt;
    logic [3:0]      r_vec, w_vec_nxt;
    logic [7:0]      r_spur, w_spur_nxt;
    logic            r_tmo, w_tmo_nxt;
    logic [3:0]      w_idx;
    logic            w_found;

    assign w_sints  = r_sync[1];
    assign BUSY     = (r_state != StIdle);
    assign SPUR_CNT = r_spur;
    assign TMO_ERR  = r_tmo;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        w_idx   = 4'd0;
        w_found = 1'b0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (r_stat[i]) begin
                w_idx   = 4'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_stat_nxt  = r_stat;
        w_mask_nxt  = r_mask;
        w_vec_nxt   = r_vec;
        w_spur_nxt  = r_spur;
        w_tmo_nxt   = r_tmo;
        PIO_RD      = 1'b0;
        PIO_WR      = 1'b0;
        PIO_ADDR    = '0;
        PIO_DATA    = '0;
        VEC         = r_vec;
        VEC_VLD     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_sints && !INH) w_state_nxt = StWaitSlot;
            end
            StWaitSlot: begin
                if (!w_sints) begin
                    w_state_nxt = StIdle;
                end else if (SLOT) begin
                    PIO_RD      = 1'b1;
                    PIO_ADDR    = RD_ADDR;
                    w_timer_nxt = TMO_LOAD;
                    w_state_nxt = StWaitStat;
                end
            end
            StWaitStat: begin
                // Returned data takes precedence over the final timer tick.
                if (STAT_VLD) begin
                    w_stat_nxt  = INT_STAT;
                    w_state_nxt = StDispatch;
                end else if (r_timer <= TW'(1)) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            StDispatch: begin
                if (w_found) begin
                    VEC         = w_idx;
                    VEC_VLD     = 1'b1;
                    w_vec_nxt   = w_idx;
                    w_mask_nxt  = NSRC'(1) << w_idx;
                    w_state_nxt = StWaitSlot2;
                end else begin
                    if (r_spur != 8'hFF) w_spur_nxt = r_spur + 8'd1;
                    w_timer_nxt = SETTLE_LOAD;
                    w_state_nxt = StSettle;
                end
            end
            StWaitSlot2: begin
                if (SLOT) begin
                    PIO_WR      = 1'b1;
                    PIO_ADDR    = CLR_ADDR;
                    PIO_DATA    = r_mask;
                    w_timer_nxt = SETTLE_LOAD;
                    w_state_nxt = StSettle;
                end
            end
            StSettle: begin
                if (r_timer <= TW'(1)) w_state_nxt = StIdle;
                else                   w_timer_nxt = r_timer - TW'(1);
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state <= StIdle;
            r_sync  <= 2'b00;
            r_timer <= '0;
            r_stat  <= '0;
            r_mask  <= '0;
            r_vec   <= 4'd0;
            r_spur  <= 8'd0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= {r_sync[0], SINT};
            r_timer <= w_timer_nxt;
            r_stat  <= w_stat_nxt;
            r_mask  <= w_mask_nxt;
            r_vec   <= w_vec_nxt;
            r_spur  <= w_spur_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_int_service_seq.sv
// Bench for int_service_seq: directed passes plus a randomized run, all checked each cycle
// against a pass-level reference model that works in absolute cycle numbers.
module tb_int_service_seq;

    localparam int         NSRC       = 14;
    localparam logic [8:0] RD_ADDR    = 9'h0A4;
    localparam logic [8:0] CLR_ADDR   = 9'h0A5;
    localparam int         TMO_CYC    = 64;
    localparam int         SETTLE_CYC = 4;

    logic            SIM_CLK, SIM_RST, SINT, INH, SLOT, STAT_VLD;
    logic [NSRC-1:0] INT_STAT;
    logic            PIO_RD, PIO_WR, VEC_VLD, BUSY, TMO_ERR;
    logic [8:0]      PIO_ADDR;
    logic [NSRC-1:0] PIO_DATA;
    logic [3:0]      VEC;
    logic [7:0]      SPUR_CNT;

    int_service_seq #(
        .RD_ADDR   (RD_ADDR),
        .CLR_ADDR  (CLR_ADDR),
        .NSRC      (NSRC),
        .TMO_CYC   (TMO_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .SINT    (SINT),
        .INH     (INH),
        .SLOT    (SLOT),
        .INT_STAT(INT_STAT),
        .STAT_VLD(STAT_VLD),
        .PIO_RD  (PIO_RD),
        .PIO_WR  (PIO_WR),
        .PIO_ADDR(PIO_ADDR),
        .PIO_DATA(PIO_DATA),
        .VEC     (VEC),
        .VEC_VLD (VEC_VLD),
        .BUSY    (BUSY),
        .SPUR_CNT(SPUR_CNT),
        .TMO_ERR (TMO_ERR)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    int checks, errors, ncyc;

    // Stimulus knobs and the status responder
    int              slot_per, resp_delay, resp_at;
    bit              slot_rand;
    logic [NSRC-1:0] resp_stat;
    logic [NSRC-1:0] stat_q[$];

    // Observations of the DUT, taken at the falling edge
    int              vec_log[$];
    logic [NSRC-1:0] wr_log[$];
    int              rd_cnt, last_rd_cyc, s_cyc;
    logic [8:0]      rd_addr_last, wr_addr_last;
    logic            s_tmo, s_busy;
    logic [7:0]      s_spur;
    logic [3:0]      s_vec;

    // Reference model: where the pass is, plus absolute-cycle deadlines
    localparam int PhIdle = 0, PhWantRd = 1, PhAwait = 2, PhDisp = 3, PhWantWr = 4, PhSettle = 5;
    int              m_ph, m_rd_cyc, m_settle_end, m_vec, m_spur;
    bit              m_tmo, m_s1, m_s2;
    logic [NSRC-1:0] m_stat, m_mask;

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NSRC-1:0] rnd_stat();
        if ($urandom_range(0, 3) == 0) return '0;
        return NSRC'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic model_reset();
        m_ph = PhIdle; m_rd_cyc = 0; m_settle_end = 0; m_vec = 0; m_spur = 0;
        m_tmo = 0; m_s1 = 0; m_s2 = 0; m_stat = '0; m_mask = '0;
    endtask

    task automatic model_cycle();
        bit              sints, e_rd, e_wr, e_vv;
        logic [8:0]      e_addr;
        logic [NSRC-1:0] e_data;
        int              e_vec;
        if (SIM_RST) model_reset();
        sints  = m_s2;
        e_rd   = (m_ph == PhWantRd) && sints && SLOT;
        e_wr   = (m_ph == PhWantWr) && SLOT;
        e_addr = e_rd ? RD_ADDR : (e_wr ? CLR_ADDR : 9'h000);
        e_data = e_wr ? m_mask : '0;
        e_vv   = (m_ph == PhDisp) && (m_stat != 0);
        e_vec  = e_vv ? lowest(m_stat) : m_vec;
        check("pio_rd",   32'(PIO_RD),   32'(e_rd));
        check("pio_wr",   32'(PIO_WR),   32'(e_wr));
        check("pio_addr", 32'(PIO_ADDR), 32'(e_addr));
        check("pio_data", 32'(PIO_DATA), 32'(e_data));
        check("vec_vld",  32'(VEC_VLD),  32'(e_vv));
        check("vec",      32'(VEC),      32'(e_vec));
        check("busy",     32'(BUSY),     32'(m_ph != PhIdle));
        check("spur_cnt", 32'(SPUR_CNT), 32'(m_spur));
        check("tmo_err",  32'(TMO_ERR),  32'(m_tmo));
        if (SIM_RST) return;
        case (m_ph)
            PhIdle:   if (sints && !INH) m_ph = PhWantRd;
            PhWantRd: begin
                if (!sints) m_ph = PhIdle;
                else if (SLOT) begin m_ph = PhAwait; m_rd_cyc = ncyc; end
            end
            PhAwait: begin
                if (STAT_VLD) begin m_stat = INT_STAT; m_ph = PhDisp; end
                else if (ncyc >= m_rd_cyc + TMO_CYC) begin m_tmo = 1; m_ph = PhIdle; end
            end
            PhDisp: begin
                if (m_stat != 0) begin
                    m_vec  = lowest(m_stat);
                    m_mask = NSRC'(1) << m_vec;
                    m_ph   = PhWantWr;
                end else begin
                    m_spur = (m_spur < 255) ? m_spur + 1 : 255;
                    m_settle_end = ncyc + SETTLE_CYC;
                    m_ph   = PhSettle;
                end
            end
            PhWantWr: if (SLOT) begin m_settle_end = ncyc + SETTLE_CYC; m_ph = PhSettle; end
            default:  if (ncyc >= m_settle_end) m_ph = PhIdle;
        endcase
        m_s2 = m_s1;
        m_s1 = SINT;
    endtask

    // One clock: check/observe at the falling edge, then drive the next cycle's inputs.
    task automatic step();
        @(negedge SIM_CLK);
        model_cycle();
        if (PIO_RD) begin
            rd_cnt++;
            last_rd_cyc  = ncyc;
            rd_addr_last = PIO_ADDR;
            resp_at      = ncyc + resp_delay;
            resp_stat    = (stat_q.size() > 0) ? stat_q.pop_front() : rnd_stat();
        end
        if (VEC_VLD) vec_log.push_back(int'(VEC));
        if (PIO_WR) begin wr_log.push_back(PIO_DATA); wr_addr_last = PIO_ADDR; end
        s_cyc = ncyc; s_tmo = TMO_ERR; s_busy = BUSY; s_spur = SPUR_CNT; s_vec = VEC;
        @(posedge SIM_CLK);
        ncyc++;
        #1;
        SLOT     = slot_rand ? ($urandom_range(0, 2) == 0) : (ncyc % slot_per == 0);
        STAT_VLD = (ncyc == resp_at);
        INT_STAT = STAT_VLD ? resp_stat : NSRC'($urandom);
    endtask

    task automatic do_reset();
        SIM_RST = 1'b1;
        resp_at = -1;
        step();
        step();
        SIM_RST = 1'b0;
    endtask

    task automatic wait_rd(input int bound);
        int r0;
        r0 = rd_cnt;
        for (int k = 0; k < bound && rd_cnt == r0; k++) step();
        check("rd_in_time", 32'(rd_cnt != r0), 32'd1);
    endtask

    task automatic wait_wr(input int bound);
        int w0;
        w0 = wr_log.size();
        for (int k = 0; k < bound && wr_log.size() == w0; k++) step();
        check("wr_in_time", 32'(wr_log.size() != w0), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && s_busy; k++) step();
        check("idle_in_time", 32'(s_busy), 32'd0);
    endtask

    initial begin
        int bv, bw, r0, rdc, rel;
        checks = 0; errors = 0; ncyc = 0; rd_cnt = 0; last_rd_cyc = 0; s_cyc = 0;
        SIM_RST = 1'b1; SINT = 0; INH = 0; SLOT = 0; STAT_VLD = 0; INT_STAT = '0;
        slot_per = 8; slot_rand = 0; resp_delay = 3; resp_at = -1; resp_stat = '0;
        s_busy = 0; s_tmo = 0; s_spur = 0; s_vec = 0;
        model_reset();
        repeat (3) step();
        SIM_RST = 1'b0;
        step();
        check("reset_busy", 32'(s_busy), 32'd0);
        check("reset_spur", 32'(s_spur), 32'd0);
        check("reset_tmo",  32'(s_tmo),  32'd0);

        // Single source
        bv = vec_log.size(); bw = wr_log.size();
        stat_q.push_back(14'h0020);
        SINT = 1;
        wait_wr(200);
        SINT = 0;
        repeat (20) step();
        check("s1_rd_addr", 32'(rd_addr_last), 32'h0A4);
        check("s1_vec", (vec_log.size() > bv) ? vec_log[bv] : -1, 32'd5);
        check("s1_wr_data", (wr_log.size() > bw) ? 32'(wr_log[bw]) : 32'hFFFF, 32'h0020);
        check("s1_wr_addr", 32'(wr_addr_last), 32'h0A5);
        check("s1_idle", 32'(s_busy), 32'd0);
        check("s1_vec_held", 32'(s_vec), 32'd5);

        // Priority and re-entry while SINT stays high
        bv = vec_log.size(); bw = wr_log.size();
        stat_q.push_back(14'h1204); stat_q.push_back(14'h1200); stat_q.push_back(14'h1000);
        SINT = 1;
        for (int k = 0; k < 600 && wr_log.size() < bw + 3; k++) step();
        SINT = 0;
        repeat (20) step();
        check("pr_nwr", wr_log.size() - bw, 32'd3);
        check("pr_vec0", (vec_log.size() > bv)     ? vec_log[bv]     : -1, 32'd2);
        check("pr_vec1", (vec_log.size() > bv + 1) ? vec_log[bv + 1] : -1, 32'd9);
        check("pr_vec2", (vec_log.size() > bv + 2) ? vec_log[bv + 2] : -1, 32'd12);
        check("pr_msk0", (wr_log.size() > bw)     ? 32'(wr_log[bw])     : 0, 32'h0004);
        check("pr_msk1", (wr_log.size() > bw + 1) ? 32'(wr_log[bw + 1]) : 0, 32'h0200);
        check("pr_msk2", (wr_log.size() > bw + 2) ? 32'(wr_log[bw + 2]) : 0, 32'h1000);

        // Spurious reads, saturating counter
        do_reset();
        bv = vec_log.size(); bw = wr_log.size();
        slot_per = 1; resp_delay = 1;
        for (int p = 0; p < 300; p++) begin
            stat_q.push_back('0);
            SINT = 1;
            wait_rd(50);
            SINT = 0;
            wait_idle(50);
            repeat (3) step();
            if (p == 0) check("spur_first", 32'(s_spur), 32'd1);
        end
        check("spur_sat", 32'(s_spur), 32'd255);
        check("spur_no_vec", vec_log.size() - bv, 32'd0);
        check("spur_no_wr", wr_log.size() - bw, 32'd0);

        // Timeout with STAT_VLD withheld
        do_reset();
        slot_per = 4; resp_delay = 1000;
        SINT = 1;
        wait_rd(50);
        SINT = 0;
        rdc = last_rd_cyc;
        for (int k = 0; k < 200 && s_cyc < rdc + TMO_CYC; k++) step();
        check("tmo_not_yet", 32'(s_tmo), 32'd0);
        check("tmo_busy", 32'(s_busy), 32'd1);
        step();
        check("tmo_set", 32'(s_tmo), 32'd1);
        check("tmo_idle", 32'(s_busy), 32'd0);

        // STAT_VLD on the last timer cycle wins
        do_reset();
        resp_delay = TMO_CYC;
        stat_q.push_back(14'h0001);
        SINT = 1;
        wait_rd(50);
        SINT = 0;
        rdc = last_rd_cyc;
        for (int k = 0; k < 200 && s_cyc < rdc + TMO_CYC + 1; k++) step();
        check("late_vld_tmo", 32'(s_tmo), 32'd0);
        check("late_vld_busy", 32'(s_busy), 32'd1);
        wait_wr(100);
        wait_idle(50);
        check("late_vld_tmo_end", 32'(s_tmo), 32'd0);

        // Inhibit
        slot_per = 8; resp_delay = 5;
        INH = 1; SINT = 1;
        r0 = rd_cnt;
        repeat (100) step();
        check("inh_no_rd", rd_cnt - r0, 32'd0);
        INH = 0;
        bw = wr_log.size();
        stat_q.push_back(14'h0100);
        wait_rd(50);
        INH = 1;
        wait_wr(100);
        check("inh_late_wr", (wr_log.size() > bw) ? 32'(wr_log[bw]) : 0, 32'h0100);
        SINT = 0;
        repeat (10) step();
        INH = 0;

        // Reset during the wait for the write slot
        stat_q.push_back(14'h0008);
        bv = vec_log.size();
        SINT = 1;
        for (int k = 0; k < 100 && vec_log.size() == bv; k++) step();
        SIM_RST = 1; resp_at = -1;
        bw = wr_log.size();
        step();
        check("rst_mid_busy", 32'(s_busy), 32'd0);
        step();
        SIM_RST = 0;
        rel = ncyc;
        stat_q.push_back(14'h0008);
        wait_rd(60);
        check("rst_no_wr", wr_log.size() - bw, 32'd0);
        check("rst_rd_delay", 32'(last_rd_cyc >= rel + 3), 32'd1);
        wait_wr(100);
        SINT = 0;
        repeat (10) step();

        // Randomized traffic
        do_reset();
        slot_rand = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) SINT = ~SINT;
            if ($urandom_range(0, 29) == 0) INH = ~INH;
            resp_delay = $urandom_range(1, 70);
            if (SIM_RST) SIM_RST = 0;
            else if ($urandom_range(0, 999) == 0) SIM_RST = 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
